// File: rtl/note_playback_pkg.sv
// note_playback_pkg: phase width, sample rate, phase-increment table and sine table
// for the note_playback sequencer.
package note_playback_pkg;

  localparam int PHASE_W        = 24;
  localparam int SAMPLE_RATE_HZ = 17000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  // Note n (1..63) is 110 Hz * 2^((n-1)/12); entry n = round(f_n * 2^PHASE_W / SAMPLE_RATE_HZ).
  localparam logic [PHASE_W-1:0] PHASE_INC [64] = '{
    24'd0,
    24'd108558,  24'd115014,  24'd121853,  24'd129098,  24'd136775,  24'd144908,
    24'd153525,  24'd162654,  24'd172326,  24'd182573,  24'd193429,  24'd204931,
    24'd217117,  24'd230027,  24'd243705,  24'd258197,  24'd273550,  24'd289816,
    24'd307050,  24'd325308,  24'd344652,  24'd365146,  24'd386858,  24'd409862,
    24'd434234,  24'd460055,  24'd487411,  24'd516394,  24'd547100,  24'd579633,
    24'd614099,  24'd650616,  24'd689303,  24'd730291,  24'd773717,  24'd819724,
    24'd868468,  24'd920109,  24'd974822,  24'd1032788, 24'd1094201, 24'd1159265,
    24'd1228199, 24'd1301231, 24'd1378606, 24'd1460583, 24'd1547433, 24'd1639449,
    24'd1736935, 24'd1840219, 24'd1949644, 24'd2065576, 24'd2188401, 24'd2318530,
    24'd2456397, 24'd2602462, 24'd2757213, 24'd2921165, 24'd3094867, 24'd3278897,
    24'd3473871, 24'd3680438, 24'd3899288
  };

  // One sine period in 64 steps; +/-128 is full scale so a >>>7 after scaling lands on AMP.
  localparam logic signed [8:0] SINE_TAB [64] = '{
    9'sd0,    9'sd13,   9'sd25,   9'sd37,   9'sd49,   9'sd60,   9'sd71,   9'sd81,
    9'sd91,   9'sd99,   9'sd106,  9'sd113,  9'sd118,  9'sd122,  9'sd126,  9'sd127,
    9'sd128,  9'sd127,  9'sd126,  9'sd122,  9'sd118,  9'sd113,  9'sd106,  9'sd99,
    9'sd91,   9'sd81,   9'sd71,   9'sd60,   9'sd49,   9'sd37,   9'sd25,   9'sd13,
    9'sd0,   -9'sd13,  -9'sd25,  -9'sd37,  -9'sd49,  -9'sd60,  -9'sd71,  -9'sd81,
   -9'sd91,  -9'sd99,  -9'sd106, -9'sd113, -9'sd118, -9'sd122, -9'sd126, -9'sd127,
   -9'sd128, -9'sd127, -9'sd126, -9'sd122, -9'sd118, -9'sd113, -9'sd106, -9'sd99,
   -9'sd91,  -9'sd81,  -9'sd71,  -9'sd60,  -9'sd49,  -9'sd37,  -9'sd25,  -9'sd13
  };

endpackage

// File: rtl/note_playback.sv
// note_playback: steps through a note score on step_in ticks and emits one signed sample per tick.
// Define NOTE_PLAYBACK_SINE_EN for sine output; the default build produces a square wave.
module note_playback
  import note_playback_pkg::*;
#(
  parameter int NUM_NOTES        = 160,
  parameter int NOTE_W           = 6,
  parameter int SAMPLES_PER_NOTE = 4096,
  parameter int AMP              = 96
) (
  input  logic                                                   clk_in,
  input  logic                                                   rst_in,
  input  logic                                                   start_in,
  input  logic                                                   stop_in,
  input  logic                                                   loop_in,
  input  logic                                                   step_in,
  input  logic [NUM_NOTES*NOTE_W-1:0]                            notes_in,
  output logic signed [7:0]                                      amp_out,
  output logic                                                   amp_valid_out,
  output logic                                                   busy_out,
  output logic [((NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1)-1:0]   note_idx_out,
  output logic                                                   done_out
);

  localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int CNT_W = (SAMPLES_PER_NOTE > 1) ? $clog2(SAMPLES_PER_NOTE) : 1;
  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(NUM_NOTES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SAMPLES_PER_NOTE - 1);
  localparam logic signed [7:0] AMP_POS   = 8'(AMP);
  localparam logic signed [7:0] AMP_NEG   = 8'(-AMP);

  state_t                state_q;
  logic [PHASE_W-1:0]    phase_q;
  logic [CNT_W-1:0]      sampleCnt_q;
  logic [IDX_W-1:0]      noteIdx_q;
  logic [NOTE_W-1:0]     note_q;
  logic signed [7:0]     amp_q;
  logic                  ampValid_q;
  logic                  done_q;

  logic                  slotEnd_d;
  logic                  lastSlot_d;
  logic [IDX_W-1:0]      nextIdx_d;
  logic [NOTE_W-1:0]     nextNote_d;
  logic [PHASE_W-1:0]    phaseInc_d;
  logic signed [7:0]     wave_d;

  logic [NOTE_W-1:0]     score [NUM_NOTES];

  for (genvar s = 0; s < NUM_NOTES; s++) begin : g_score
    assign score[s] = notes_in[s*NOTE_W +: NOTE_W];
  end

`ifdef NOTE_PLAYBACK_SINE_EN
  localparam logic signed [17:0] AMP_WIDE = 18'(AMP);
  logic signed [17:0] sineProd_d;
`endif

  // Table lookups and the sample for the current phase; the phase used is the one before this tick's add.
  always_comb begin
    slotEnd_d  = (sampleCnt_q == LAST_CNT);
    lastSlot_d = (noteIdx_q == LAST_SLOT);
    nextIdx_d  = lastSlot_d ? '0 : noteIdx_q + 1'b1;
    nextNote_d = score[nextIdx_d];
    phaseInc_d = PHASE_INC[6'(note_q)];
`ifdef NOTE_PLAYBACK_SINE_EN
    sineProd_d = 18'(SINE_TAB[phase_q[PHASE_W-1 -: 6]]) * AMP_WIDE;
    wave_d     = 8'(sineProd_d >>> 7);
`else
    wave_d     = phase_q[PHASE_W-1] ? AMP_NEG : AMP_POS;
`endif
    if (note_q == '0) begin
      wave_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      sampleCnt_q <= '0;
      noteIdx_q   <= '0;
      note_q      <= '0;
      amp_q       <= '0;
      ampValid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ampValid_q <= step_in;
      done_q     <= 1'b0;
      if (step_in) begin
        amp_q <= (state_q == S_PLAY && !stop_in) ? wave_d : '0;
      end else if (state_q == S_IDLE) begin
        amp_q <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_in && !stop_in) begin
            state_q     <= S_PLAY;
            phase_q     <= '0;
            sampleCnt_q <= '0;
            noteIdx_q   <= '0;
            note_q      <= score[0];
          end
        end
        S_PLAY: begin
          if (stop_in) begin
            state_q <= S_IDLE;
          end else if (step_in) begin
            if (slotEnd_d) begin
              sampleCnt_q <= '0;
              phase_q     <= '0;
              noteIdx_q   <= nextIdx_d;
              note_q      <= nextNote_d;
              if (lastSlot_d && !loop_in) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end
            end else begin
              sampleCnt_q <= sampleCnt_q + 1'b1;
              if (note_q != '0) begin
                phase_q <= phase_q + phaseInc_d;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign amp_out       = amp_q;
  assign amp_valid_out = ampValid_q;
  assign busy_out      = (state_q == S_PLAY);
  assign note_idx_out  = noteIdx_q;
  assign done_out      = done_q;

endmodule
